// File: rtl/hamming_deserializer_if.sv
// Bit-strobe input, codeword output and error pulses of the deserializer.
// Handshake: a codeword transfers on every rising clk edge where
// code_valid and code_ready are both 1; while code_valid=1 and
// code_ready=0 the source holds code_out stable.
interface hamming_deserializer_if #(
  parameter int CODE_W = 12
);
  logic              bit_en;
  logic              rx_bit;
  logic [CODE_W:1]   code_out;
  logic              code_valid;
  logic              code_ready;
  logic              frame_err;
  logic              overrun;

  modport master (
    input  bit_en, rx_bit, code_ready,
    output code_out, code_valid, frame_err, overrun
  );

  modport slave (
    output bit_en, rx_bit, code_ready,
    input  code_out, code_valid, frame_err, overrun
  );
endinterface

// File: rtl/hamming_deserializer.sv
// Framed serial receiver: start bit, CODE_W data bits LSB-first, stop bit.
// Good frames are buffered in a small FIFO whose head feeds the decoder.
module hamming_deserializer #(
  parameter int CODE_W = 12,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  hamming_deserializer_if.master     bus,
  output logic [1:0]                 state_dbg,
  output logic [$clog2(DEPTH):0]     count_dbg
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CODE_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t            state;
  logic [BW-1:0]     bitcnt;
  logic [CODE_W:1]   shreg;
  logic              frame_err_q;
  logic              overrun_q;

  logic [CODE_W:1]   mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic              code_valid;
  logic              pop;
  logic              push_req;
  logic              push_ok;

  assign code_valid = (count != '0);
  assign pop        = code_valid & bus.code_ready;
  assign push_req   = (state == STOP) & bus.bit_en & bus.rx_bit;
  // A full FIFO still accepts when its head leaves in the same cycle.
  assign push_ok    = push_req & ((count < CW'(DEPTH)) | pop);

  assign bus.code_out   = mem[rd_ptr];
  assign bus.code_valid = code_valid;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;
  assign state_dbg      = state;
  assign count_dbg      = count;

  // Frame FSM: start detect, LSB-first data shift, stop-bit check.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bitcnt      <= '0;
      shreg       <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (bus.bit_en) begin
        case (state)
          IDLE: begin
            if (!bus.rx_bit) begin
              state  <= DATA;
              bitcnt <= '0;
            end
          end
          DATA: begin
            // Shifting in from the top leaves the first bit at position 1
            // once all CODE_W bits have arrived.
            shreg  <= {bus.rx_bit, shreg[CODE_W:2]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == BW'(CODE_W - 1)) state <= STOP;
          end
          STOP: begin
            if (bus.rx_bit) overrun_q   <= ~push_ok;
            else            frame_err_q <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Codeword FIFO: pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_hamming_deserializer.sv
// Directed bench for hamming_deserializer: frames driven on the falling
// edge, outputs checked on the falling edge after each rising edge.
module tb_hamming_deserializer;
  logic clk;
  logic rst;
  logic [1:0] state_dbg;
  logic [1:0] count_dbg;
  int n_tests;
  int n_fail;

  hamming_deserializer_if #(.CODE_W(12)) bus ();

  hamming_deserializer #(.CODE_W(12), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg),
    .count_dbg (count_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_bit(input logic b);
    @(negedge clk);
    bus.bit_en = 1'b1;
    bus.rx_bit = b;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.bit_en = 1'b0;
    bus.rx_bit = 1'b1;
  endtask

  task automatic send_body(input logic [11:0] code);
    drive_bit(1'b0);
    for (int i = 0; i < 12; i++) drive_bit(code[i]);
  endtask

  // Returns on the falling edge just after the stop bit was sampled.
  task automatic send_frame(input logic [11:0] code, input logic stop);
    send_body(code);
    drive_bit(stop);
    idle();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.bit_en = 1'b0;
    bus.rx_bit = 1'b1;
    bus.code_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_valid", 32'(bus.code_valid), 32'h0);
    check("rst_out", 32'(bus.code_out), 32'h0);
    check("rst_ferr", 32'(bus.frame_err), 32'h0);
    check("rst_ovr", 32'(bus.overrun), 32'h0);
    check("rst_state", 32'(state_dbg), 32'h0);
    check("rst_count", 32'(count_dbg), 32'h0);

    // Single frame with consumer ready: valid for exactly one cycle
    bus.code_ready = 1'b1;
    send_frame(12'hA5C, 1'b1);
    check("single_valid", 32'(bus.code_valid), 32'h1);
    check("single_out", 32'(bus.code_out), 32'hA5C);
    check("single_ferr", 32'(bus.frame_err), 32'h0);
    check("single_ovr", 32'(bus.overrun), 32'h0);
    @(negedge clk);
    check("single_valid_drop", 32'(bus.code_valid), 32'h0);

    // Bad stop bit, then a good frame
    send_frame(12'h123, 1'b0);
    check("ferr_pulse", 32'(bus.frame_err), 32'h1);
    check("ferr_valid", 32'(bus.code_valid), 32'h0);
    @(negedge clk);
    check("ferr_one_cycle", 32'(bus.frame_err), 32'h0);
    send_frame(12'h456, 1'b1);
    check("after_ferr_valid", 32'(bus.code_valid), 32'h1);
    check("after_ferr_out", 32'(bus.code_out), 32'h456);
    @(negedge clk);
    check("after_ferr_drain", 32'(bus.code_valid), 32'h0);

    // Backpressure: third frame overruns
    bus.code_ready = 1'b0;
    send_frame(12'h001, 1'b1);
    check("bp_count1", 32'(count_dbg), 32'h1);
    send_frame(12'h002, 1'b1);
    check("bp_count2", 32'(count_dbg), 32'h2);
    check("bp_hold", 32'(bus.code_out), 32'h001);
    send_frame(12'h003, 1'b1);
    check("bp_ovr", 32'(bus.overrun), 32'h1);
    check("bp_count_full", 32'(count_dbg), 32'h2);
    @(negedge clk);
    check("bp_ovr_one_cycle", 32'(bus.overrun), 32'h0);
    bus.code_ready = 1'b1;
    check("bp_out1", 32'(bus.code_out), 32'h001);
    @(negedge clk);
    check("bp_valid2", 32'(bus.code_valid), 32'h1);
    check("bp_out2", 32'(bus.code_out), 32'h002);
    @(negedge clk);
    check("bp_empty", 32'(bus.code_valid), 32'h0);

    // Full FIFO, pop coincides with the stop-bit push
    bus.code_ready = 1'b0;
    send_frame(12'h001, 1'b1);
    send_frame(12'h002, 1'b1);
    send_body(12'h003);
    drive_bit(1'b1);
    check("coin_head1", 32'(bus.code_out), 32'h001);
    bus.code_ready = 1'b1;
    idle();
    check("coin_no_ovr", 32'(bus.overrun), 32'h0);
    check("coin_count", 32'(count_dbg), 32'h2);
    check("coin_head2", 32'(bus.code_out), 32'h002);
    @(negedge clk);
    check("coin_head3", 32'(bus.code_out), 32'h003);
    check("coin_count1", 32'(count_dbg), 32'h1);
    @(negedge clk);
    check("coin_empty", 32'(bus.code_valid), 32'h0);

    // Back-to-back frames with no idle gap
    send_body(12'h3C5);
    drive_bit(1'b1);
    send_body(12'h5A3);
    drive_bit(1'b1);
    idle();
    check("b2b_valid", 32'(bus.code_valid), 32'h1);
    check("b2b_out", 32'(bus.code_out), 32'h5A3);
    @(negedge clk);

    // Reset mid-frame with one entry buffered
    bus.code_ready = 1'b0;
    send_frame(12'h0AA, 1'b1);
    check("mid_count", 32'(count_dbg), 32'h1);
    drive_bit(1'b0);
    for (int i = 0; i < 5; i++) drive_bit(1'b1);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", 32'(bus.code_valid), 32'h0);
    check("mid_rst_out", 32'(bus.code_out), 32'h0);
    check("mid_rst_ferr", 32'(bus.frame_err), 32'h0);
    check("mid_rst_ovr", 32'(bus.overrun), 32'h0);
    check("mid_rst_state", 32'(state_dbg), 32'h0);
    check("mid_rst_count", 32'(count_dbg), 32'h0);
    bus.code_ready = 1'b1;
    send_frame(12'hFFF, 1'b1);
    check("post_rst_valid", 32'(bus.code_valid), 32'h1);
    check("post_rst_out", 32'(bus.code_out), 32'hFFF);
    @(negedge clk);

    // Sparse strobes with a glitching line between them
    begin
      logic [13:0] frame;
      frame = {1'b1, 12'h8C3, 1'b0};
      for (int i = 0; i < 14; i++) begin
        drive_bit(frame[i]);
        for (int g = 0; g < 6; g++) begin
          @(negedge clk);
          bus.bit_en = 1'b0;
          bus.rx_bit = 1'($urandom_range(0, 1));
          if (i == 13 && g == 0) begin
            check("sparse_valid", 32'(bus.code_valid), 32'h1);
            check("sparse_out", 32'(bus.code_out), 32'h8C3);
            check("sparse_ferr", 32'(bus.frame_err), 32'h0);
          end
        end
      end
      bus.rx_bit = 1'b1;
    end
    @(negedge clk);
    check("sparse_drain", 32'(bus.code_valid), 32'h0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
